display_scheduler: RTL and testbench

- Sequences the FND display path.
- Owns the NORMAL/DISPLAY mode, selects which info page is shown while in DISPLAY, and returns to NORMAL automatically after an idle timeout.
- Generates the 4-digit scan strobe (digit index plus active-low anodes) consumed by the segment mux.
- Sits between the debounced button pulses / mixer busy flag and the FND driver.

---
 rtl/display_scheduler.sv | 119 +++++++++++
 tb/tb_display_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - FND display sequencer: NORMAL/DISPLAY mode, info page select,
// idle auto-return and the 4-digit scan strobe feeding the segment mux.
module display_scheduler #(
  parameter int SCAN_DIV      = 100000,
  parameter int TIMEOUT_TICKS = 5000,
  parameter int NUM_PAGES     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic       nxt,
  input  logic       lock,
  output logic       mode,
  output logic [1:0] page,
  output logic [1:0] digit_idx,
  output logic [3:0] digit_an,
  output logic       timeout
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDLE_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_TICKS - 1);
  localparam logic [1:0]        PAGE_LAST = 2'(NUM_PAGES - 1);

  typedef enum logic {
    NORMAL  = 1'b0,
    DISPLAY = 1'b1
  } state_t;

  state_t            state, state_nx;
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDLE_W-1:0] idle, idle_nx;
  logic [1:0]        page_nx;
  logic [1:0]        idx_nx;
  logic              timeout_nx;
  logic              sig_q, nxt_q;
  logic              sig_p, nxt_p;
  logic              tick;

  assign sig_p  = sig & ~sig_q;
  assign nxt_p  = nxt & ~nxt_q;
  assign tick   = (scan_cnt == SCAN_LAST);
  assign idx_nx = digit_idx + 2'd1;
  assign mode   = (state == DISPLAY);

  // Scan strobe free-runs in both modes; lock never stalls it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
      digit_an  <= 4'b1110;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + SCAN_W'(1);
      if (tick) begin
        digit_idx <= idx_nx;
        digit_an  <= ~(4'b0001 << idx_nx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= NORMAL;
      page    <= 2'd0;
      idle    <= '0;
      timeout <= 1'b0;
      sig_q   <= 1'b0;
      nxt_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      page    <= page_nx;
      idle    <= idle_nx;
      timeout <= timeout_nx;
      sig_q   <= sig;
      nxt_q   <= nxt;
    end
  end

  // Exit causes in DISPLAY are ordered lock > sig > idle timeout > page advance.
  always_comb begin
    state_nx   = state;
    page_nx    = page;
    idle_nx    = idle;
    timeout_nx = 1'b0;
    case (state)
      NORMAL: begin
        page_nx = 2'd0;
        idle_nx = '0;
        if (sig_p && !lock) begin
          state_nx = DISPLAY;
        end
      end
      DISPLAY: begin
        if (lock || sig_p) begin
          state_nx = NORMAL;
          page_nx  = 2'd0;
          idle_nx  = '0;
        end else if (tick && (idle == IDLE_LAST)) begin
          state_nx   = NORMAL;
          page_nx    = 2'd0;
          idle_nx    = '0;
          timeout_nx = 1'b1;
        end else if (nxt_p) begin
          page_nx = (page == PAGE_LAST) ? 2'd0 : page + 2'd1;
          idle_nx = '0;
        end else if (tick) begin
          idle_nx = idle + IDLE_W'(1);
        end
      end
      default: begin
        state_nx = NORMAL;
        page_nx  = 2'd0;
        idle_nx  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - scoreboard bench for display_scheduler
// (SCAN_DIV=4, TIMEOUT_TICKS=3, NUM_PAGES=3).
module tb_display_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sig = 1'b0;
  logic       nxt = 1'b0;
  logic       lock = 1'b0;
  logic       mode;
  logic [1:0] page;
  logic [1:0] digit_idx;
  logic [3:0] digit_an;
  logic       timeout;

  always #5 clk = ~clk;

  display_scheduler #(
    .SCAN_DIV(4),
    .TIMEOUT_TICKS(3),
    .NUM_PAGES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sig(sig),
    .nxt(nxt),
    .lock(lock),
    .mode(mode),
    .page(page),
    .digit_idx(digit_idx),
    .digit_an(digit_an),
    .timeout(timeout)
  );

  typedef struct {
    int         cyc;
    logic       mode;
    logic [1:0] page;
    logic       tmo;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc;
  int   imm_req = 0;
  int   imm_seen = 0;

  // Clock edges counted since reset release; cyc = -1 marks a between-edges check.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic push(input int c, input logic m, input logic [1:0] p, input logic t,
                      input string n);
    exp_t e;
    e.cyc = c; e.mode = m; e.page = p; e.tmo = t; e.name = n;
    sb.push_back(e);
  endtask

  task automatic push_range(input int c0, input int c1, input logic m, input logic [1:0] p,
                            input logic t, input string n);
    for (int c = c0; c <= c1; c++) push(c, m, p, t, n);
  endtask

  task automatic compare(input exp_t e);
    logic [1:0] ei;
    logic [3:0] one;
    logic [3:0] ea;
    ei  = (e.cyc < 0) ? 2'd0 : 2'((e.cyc / 4) % 4);
    one = 4'b0001 << ei;
    ea  = ~one;
    checks++;
    if ({mode, page, digit_idx, digit_an, timeout} !== {e.mode, e.page, ei, ea, e.tmo}) begin
      errors++;
      $display("FAIL %s @cyc %0d: got mode=%b page=%0d idx=%0d an=%b tmo=%b, want mode=%b page=%0d idx=%0d an=%b tmo=%b",
               e.name, e.cyc, mode, page, digit_idx, digit_an, timeout,
               e.mode, e.page, ei, ea, e.tmo);
    end
  endtask

  always begin
    int  want;
    bit  imm;
    @(negedge clk or imm_req);
    imm      = (imm_req != imm_seen);
    imm_seen = imm_req;
    if (imm || rst) begin
      want = imm ? -1 : cyc;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == want) begin
          compare(sb[i]);
          sb.delete(i);
        end else if (!imm && sb[i].cyc >= 0 && sb[i].cyc < want) begin
          checks++;
          errors++;
          $display("FAIL %s: check for cycle %0d skipped (now %0d)", sb[i].name, sb[i].cyc, want);
          sb.delete(i);
        end
      end
    end
  end

  task automatic at(input int n);
    int g;
    g = 0;
    while (cyc != n) begin
      @(posedge clk);
      #1;
      g++;
      if (g > 500) begin
        errors++;
        checks++;
        $display("FAIL at_cycle: reached %0d, required %0d", cyc, n);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "stimulus timeline lost");
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    push_range(0, 16, 1'b0, 2'd0, 1'b0, "scan_free_run");

    // Held sig: one toggle, then idle timeout three ticks later.
    at(20); sig = 1'b1;
    push(20, 1'b0, 2'd0, 1'b0, "pre_entry");
    push_range(21, 30, 1'b1, 2'd0, 1'b0, "entry_hold");
    at(30); sig = 1'b0;
    push(31, 1'b1, 2'd0, 1'b0, "display_idle");
    push(32, 1'b0, 2'd0, 1'b1, "timeout_pulse");
    push(33, 1'b0, 2'd0, 1'b0, "timeout_clear");

    // Page stepping with wrap, then sig exit.
    at(39); sig = 1'b1;
    push(40, 1'b1, 2'd0, 1'b0, "enter2");
    at(40); sig = 1'b0;
    at(42); nxt = 1'b1; push(43, 1'b1, 2'd1, 1'b0, "page1");
    at(43); nxt = 1'b0;
    at(45); nxt = 1'b1; push(46, 1'b1, 2'd2, 1'b0, "page2");
    at(46); nxt = 1'b0;
    at(47); nxt = 1'b1; push(48, 1'b1, 2'd0, 1'b0, "page_wrap");
    at(48); nxt = 1'b0;
    at(49); nxt = 1'b1; push(50, 1'b1, 2'd1, 1'b0, "page1_again");
    at(50); nxt = 1'b0;
    at(51); sig = 1'b1;
    push(51, 1'b1, 2'd1, 1'b0, "pre_exit");
    push(52, 1'b0, 2'd0, 1'b0, "sig_exit");
    at(52); sig = 1'b0;

    // nxt after two ticks restarts the idle count.
    at(55); sig = 1'b1; push(56, 1'b1, 2'd0, 1'b0, "enter3");
    at(56); sig = 1'b0;
    push(64, 1'b1, 2'd0, 1'b0, "two_ticks");
    at(65); nxt = 1'b1; push(66, 1'b1, 2'd1, 1'b0, "restart_press");
    at(66); nxt = 1'b0;
    push(68, 1'b1, 2'd1, 1'b0, "restarted_t1");
    push(72, 1'b1, 2'd1, 1'b0, "restarted_t2");
    push(75, 1'b1, 2'd1, 1'b0, "pre_timeout");
    push(76, 1'b0, 2'd0, 1'b1, "timeout_after_press");
    push(77, 1'b0, 2'd0, 1'b0, "timeout_one_cycle");

    // nxt coinciding with the timeout tick loses.
    at(79); sig = 1'b1; push(80, 1'b1, 2'd0, 1'b0, "enter4");
    at(80); sig = 1'b0;
    at(91); nxt = 1'b1;
    push(91, 1'b1, 2'd0, 1'b0, "pre_coincide");
    push(92, 1'b0, 2'd0, 1'b1, "timeout_beats_nxt");
    at(92); nxt = 1'b0;
    push(93, 1'b0, 2'd0, 1'b0, "after_coincide");

    // lock blocks entry, is not queued, and forces exit without timeout.
    at(95); lock = 1'b1;
    at(96); sig = 1'b1; push(97, 1'b0, 2'd0, 1'b0, "lock_blocks");
    at(98); sig = 1'b0; lock = 1'b0;
    push(99, 1'b0, 2'd0, 1'b0, "lock_no_queue");
    push(100, 1'b0, 2'd0, 1'b0, "lock_no_queue2");
    at(100); sig = 1'b1; push(101, 1'b1, 2'd0, 1'b0, "enter5");
    at(101); sig = 1'b0;
    at(103); lock = 1'b1;
    push(103, 1'b1, 2'd0, 1'b0, "pre_lock");
    push(104, 1'b0, 2'd0, 1'b0, "lock_exits");
    push(105, 1'b0, 2'd0, 1'b0, "lock_no_timeout");
    at(104); lock = 1'b0;

    // Simultaneous sig and nxt presses: sig wins.
    at(106); sig = 1'b1; push(107, 1'b1, 2'd0, 1'b0, "enter6");
    at(107); sig = 1'b0;
    at(108); nxt = 1'b1; push(109, 1'b1, 2'd1, 1'b0, "page1_b");
    at(109); nxt = 1'b0;
    at(110); sig = 1'b1; nxt = 1'b1;
    push(110, 1'b1, 2'd1, 1'b0, "pre_both");
    push(111, 1'b0, 2'd0, 1'b0, "sig_beats_nxt");
    at(111); sig = 1'b0; nxt = 1'b0;
    push(112, 1'b0, 2'd0, 1'b0, "after_both");

    // Asynchronous reset mid-DISPLAY at page 2, digit 3.
    at(115); sig = 1'b1; push(116, 1'b1, 2'd0, 1'b0, "enter7");
    at(116); sig = 1'b0;
    at(117); nxt = 1'b1; push(118, 1'b1, 2'd1, 1'b0, "page1_c");
    at(118); nxt = 1'b0;
    at(119); nxt = 1'b1; push(120, 1'b1, 2'd2, 1'b0, "page2_c");
    at(120); nxt = 1'b0;
    push(125, 1'b1, 2'd2, 1'b0, "pre_reset_state");
    at(125);
    @(negedge clk);
    #2 rst = 1'b0; sig = 1'b1;
    #1 push(-1, 1'b0, 2'd0, 1'b0, "async_reset");
    imm_req++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    push(0, 1'b0, 2'd0, 1'b0, "release_idle");
    push_range(1, 6, 1'b1, 2'd0, 1'b0, "held_through_reset");
    at(6); sig = 1'b0;
    push(7, 1'b1, 2'd0, 1'b0, "single_press");
    push(11, 1'b1, 2'd0, 1'b0, "pre_final");
    push(12, 1'b0, 2'd0, 1'b1, "final_timeout");
    push(13, 1'b0, 2'd0, 1'b0, "final_clear");
    at(15);
    repeat (2) @(posedge clk);

    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: check for cycle %0d never performed", sb[i].name, sb[i].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
